writeback_queue: RTL and testbench

Result-side producer for the register unit's write port. Accepts completed results from the ALU path and the load/store (memory) path through valid/ready handshakes, buffers them in a small in-order FIFO, and presents one write per cycle (`wb_valid`, `wb_rd`, `wb_data`) to the register unit. It also reports read-after-write hazards for the source registers currently being decoded, so the pipeline can stall until pending writes have drained.

---
 rtl/writeback_queue_if.sv | 56 +++++
 rtl/writeback_queue.sv | 108 ++++++++++
 tb/tb_writeback_queue.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/writeback_queue_if.sv
// rtl/writeback_queue_if.sv - handshake, write-port and hazard-query signals of the writeback queue
//
// Signals:
//   alu_valid/alu_ready/alu_rd/alu_data  ALU result handshake
//   mem_valid/mem_ready/mem_rd/mem_data  load result handshake
//   wb_valid/wb_accept/wb_rd/wb_data     register-unit write port
//   query_rs1/query_rs2                  source indices in decode
//   hazard_rs1/hazard_rs2                pending-write hits on those sources
//   count                                occupied entries
// The queue connects through the slave modport; its environment uses master.

interface writeback_queue_if #(
    parameter int depth = 4
);
    logic                     alu_valid;
    logic                     alu_ready;
    logic [4:0]               alu_rd;
    logic [31:0]              alu_data;
    logic                     mem_valid;
    logic                     mem_ready;
    logic [4:0]               mem_rd;
    logic [31:0]              mem_data;
    logic                     wb_valid;
    logic                     wb_accept;
    logic [4:0]               wb_rd;
    logic [31:0]              wb_data;
    logic [4:0]               query_rs1;
    logic [4:0]               query_rs2;
    logic                     hazard_rs1;
    logic                     hazard_rs2;
    logic [$clog2(depth):0]   count;

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  mem_valid, mem_rd, mem_data,
        output mem_ready,
        output wb_valid, wb_rd, wb_data,
        input  wb_accept,
        input  query_rs1, query_rs2,
        output hazard_rs1, hazard_rs2,
        output count
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output mem_valid, mem_rd, mem_data,
        input  mem_ready,
        input  wb_valid, wb_rd, wb_data,
        output wb_accept,
        output query_rs1, query_rs2,
        input  hazard_rs1, hazard_rs2,
        input  count
    );
endinterface

// File: rtl/writeback_queue.sv
// rtl/writeback_queue.sv - in-order result FIFO feeding the register-file write port, with RAW hazard lookup
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-low reset (0 = reset)
//   bus    writeback_queue_if.slave: ALU and load result handshakes,
//          register write port, hazard queries and occupancy count

module writeback_queue #(
    parameter int depth = 4
) (
    input  logic               clk,
    input  logic               reset,
    writeback_queue_if.slave   bus
);
    localparam int aw = $clog2(depth);

    logic [4:0]    rd_q   [depth];
    logic [31:0]   data_q [depth];
    logic [aw-1:0] head_q;
    logic [aw-1:0] tail_q;
    logic [aw:0]   count_q;

    logic [aw:0]   free;
    logic          mem_ready;
    logic          alu_ready;
    logic          mem_push;
    logic          alu_push;
    logic          pop;
    logic [1:0]    push_cnt;
    logic [aw-1:0] alu_slot;

    // Readiness looks only at registered occupancy so that a pop never
    // opens a slot for a push in the same cycle.
    assign free      = (aw+1)'(depth) - count_q;
    assign mem_ready = (free != '0);
    // Memory results have priority for the last free slot.
    assign alu_ready = (free >= (aw+1)'(2)) || ((free == (aw+1)'(1)) && !bus.mem_valid);

    // Writes to x0 complete the handshake but never occupy an entry.
    assign mem_push = bus.mem_valid && mem_ready && (bus.mem_rd != 5'd0);
    assign alu_push = bus.alu_valid && alu_ready && (bus.alu_rd != 5'd0);
    assign pop      = (count_q != '0) && bus.wb_accept;

    assign push_cnt = {1'b0, mem_push} + {1'b0, alu_push};
    // On a double push the load result is the older one and takes tail.
    assign alu_slot = mem_push ? (tail_q + aw'(1)) : tail_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < depth; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            // Popped entries are cleared so an empty queue presents zeros.
            // A pushed slot can never coincide with the popped head because
            // pushes are gated on the pre-pop free space.
            if (pop) begin
                rd_q[head_q]   <= '0;
                data_q[head_q] <= '0;
                head_q         <= head_q + aw'(1);
            end
            if (mem_push) begin
                rd_q[tail_q]   <= bus.mem_rd;
                data_q[tail_q] <= bus.mem_data;
            end
            if (alu_push) begin
                rd_q[alu_slot]   <= bus.alu_rd;
                data_q[alu_slot] <= bus.alu_data;
            end
            tail_q  <= tail_q + aw'(push_cnt);
            count_q <= count_q + (aw+1)'(push_cnt) - (aw+1)'(pop);
        end
    end

    // Hazard lookup covers only entries between head and head+count; the
    // current cycle's incoming results are deliberately not visible.
    always_comb begin
        logic [aw-1:0] offset;
        logic          occupied;
        bus.hazard_rs1 = 1'b0;
        bus.hazard_rs2 = 1'b0;
        offset         = '0;
        occupied       = 1'b0;
        for (int i = 0; i < depth; i++) begin
            offset   = aw'(i) - head_q;
            occupied = ({1'b0, offset} < count_q);
            if (occupied && (bus.query_rs1 != 5'd0) && (rd_q[i] == bus.query_rs1)) begin
                bus.hazard_rs1 = 1'b1;
            end
            if (occupied && (bus.query_rs2 != 5'd0) && (rd_q[i] == bus.query_rs2)) begin
                bus.hazard_rs2 = 1'b1;
            end
        end
    end

    assign bus.alu_ready = alu_ready;
    assign bus.mem_ready = mem_ready;
    assign bus.wb_valid  = (count_q != '0);
    assign bus.wb_rd     = rd_q[head_q];
    assign bus.wb_data   = data_q[head_q];
    assign bus.count     = count_q;

endmodule

// File: tb/tb_writeback_queue.sv
// tb/tb_writeback_queue.sv - directed vector table plus randomized run against a queue-based reference model

module tb_writeback_queue;
    localparam int depth = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    writeback_queue_if #(.depth(depth)) bus();

    writeback_queue #(.depth(depth)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adata;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] mdata;
        logic        acc;
        logic [4:0]  q1;
        logic [4:0]  q2;
        logic        e_wbv;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        logic [2:0]  e_cnt;
        logic        e_ar;
        logic        e_mr;
        logic        e_h1;
        logic        e_h2;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;

    vec_t tbl[$];
    ent_t mq[$];

    int vectors     = 0;
    int miscompares = 0;

    function automatic vec_t mk(
        input logic rst, input logic av, input logic [4:0] ard, input logic [31:0] adata,
        input logic mv, input logic [4:0] mrd, input logic [31:0] mdata,
        input logic acc, input logic [4:0] q1, input logic [4:0] q2,
        input logic e_wbv, input logic [4:0] e_rd, input logic [31:0] e_data,
        input logic [2:0] e_cnt, input logic e_ar, input logic e_mr,
        input logic e_h1, input logic e_h2);
        vec_t v;
        v.rst = rst; v.av = av; v.ard = ard; v.adata = adata;
        v.mv = mv; v.mrd = mrd; v.mdata = mdata;
        v.acc = acc; v.q1 = q1; v.q2 = q2;
        v.e_wbv = e_wbv; v.e_rd = e_rd; v.e_data = e_data; v.e_cnt = e_cnt;
        v.e_ar = e_ar; v.e_mr = e_mr; v.e_h1 = e_h1; v.e_h2 = e_h2;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0d: got %0h, required %0h", name, idx, act, exp);
        end
    endtask

    function automatic logic model_hit(input logic [4:0] q);
        if (q == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].rd == q) return 1'b1;
        return 1'b0;
    endfunction

    // mode 0: no checks, 1: compare against table expectations, 2: compare against model
    task automatic step(input vec_t v, input int mode, input int idx);
        int          m_cnt;
        int          m_free;
        logic        m_mr, m_ar, m_wbv;
        logic [4:0]  m_rd;
        logic [31:0] m_data;
        @(negedge clk);
        reset         = v.rst;
        bus.alu_valid = v.av;
        bus.alu_rd    = v.ard;
        bus.alu_data  = v.adata;
        bus.mem_valid = v.mv;
        bus.mem_rd    = v.mrd;
        bus.mem_data  = v.mdata;
        bus.wb_accept = v.acc;
        bus.query_rs1 = v.q1;
        bus.query_rs2 = v.q2;
        #1;
        m_cnt  = mq.size();
        m_free = depth - m_cnt;
        m_mr   = (m_free >= 1);
        m_ar   = (m_free >= 2) || (m_free == 1 && !v.mv);
        m_wbv  = (m_cnt != 0);
        m_rd   = m_wbv ? mq[0].rd : 5'd0;
        m_data = m_wbv ? mq[0].d  : 32'd0;
        if (mode == 1) begin
            check("tbl_wb_valid",  idx, 32'(bus.wb_valid),   32'(v.e_wbv));
            check("tbl_wb_rd",     idx, 32'(bus.wb_rd),      32'(v.e_rd));
            check("tbl_wb_data",   idx, bus.wb_data,         v.e_data);
            check("tbl_count",     idx, 32'(bus.count),      32'(v.e_cnt));
            check("tbl_alu_ready", idx, 32'(bus.alu_ready),  32'(v.e_ar));
            check("tbl_mem_ready", idx, 32'(bus.mem_ready),  32'(v.e_mr));
            check("tbl_hazard1",   idx, 32'(bus.hazard_rs1), 32'(v.e_h1));
            check("tbl_hazard2",   idx, 32'(bus.hazard_rs2), 32'(v.e_h2));
        end else if (mode == 2) begin
            check("rnd_wb_valid",  idx, 32'(bus.wb_valid),   32'(m_wbv));
            check("rnd_wb_rd",     idx, 32'(bus.wb_rd),      32'(m_rd));
            check("rnd_wb_data",   idx, bus.wb_data,         m_data);
            check("rnd_count",     idx, 32'(bus.count),      32'(m_cnt));
            check("rnd_alu_ready", idx, 32'(bus.alu_ready),  32'(m_ar));
            check("rnd_mem_ready", idx, 32'(bus.mem_ready),  32'(m_mr));
            check("rnd_hazard1",   idx, 32'(bus.hazard_rs1), 32'(model_hit(v.q1)));
            check("rnd_hazard2",   idx, 32'(bus.hazard_rs2), 32'(model_hit(v.q2)));
        end
        @(posedge clk);
        if (!v.rst) begin
            mq.delete();
        end else begin
            if (m_wbv && v.acc) void'(mq.pop_front());
            if (v.mv && m_mr && v.mrd != 5'd0) mq.push_back('{rd: v.mrd, d: v.mdata});
            if (v.av && m_ar && v.ard != 5'd0) mq.push_back('{rd: v.ard, d: v.adata});
        end
    endtask

    initial begin
        vec_t v;
        // rst av ard adata  mv mrd mdata  acc q1 q2 | wbv rd data cnt ar mr h1 h2
        // reset released, idle
        tbl.push_back(mk(1,0,0,0, 0,0,0, 0,5,0,   0,0,0,0, 1,1,0,0));
        // single ALU push rd3, then hold, then accept
        tbl.push_back(mk(1,1,3,32'h1234_5678, 0,0,0, 0,0,3,   0,0,0,0, 1,1,0,0));
        tbl.push_back(mk(1,0,0,0, 0,0,0, 0,0,3,   1,3,32'h1234_5678,1, 1,1,0,1));
        tbl.push_back(mk(1,0,0,0, 0,0,0, 1,0,3,   1,3,32'h1234_5678,1, 1,1,0,1));
        tbl.push_back(mk(1,0,0,0, 0,0,0, 0,0,3,   0,0,0,0, 1,1,0,0));
        // dual push: mem rd7 older than alu rd8; accept on empty is ignored
        tbl.push_back(mk(1,1,8,32'hBBBB_BBBB, 1,7,32'hAAAA_AAAA, 1,7,8,   0,0,0,0, 1,1,0,0));
        tbl.push_back(mk(1,0,0,0, 0,0,0, 1,7,8,   1,7,32'hAAAA_AAAA,2, 1,1,1,1));
        tbl.push_back(mk(1,0,0,0, 0,0,0, 1,7,8,   1,8,32'hBBBB_BBBB,1, 1,1,0,1));
        tbl.push_back(mk(1,0,0,0, 0,0,0, 0,7,8,   0,0,0,0, 1,1,0,0));
        // x0 filter
        tbl.push_back(mk(1,1,0,32'hFFFF_FFFF, 0,0,0, 0,0,0,   0,0,0,0, 1,1,0,0));
        tbl.push_back(mk(1,0,0,0, 0,0,0, 0,0,0,   0,0,0,0, 1,1,0,0));
        // fill to 3, then last-slot arbitration
        tbl.push_back(mk(1,1,2,32'h22, 1,1,32'h11, 0,0,0,   0,0,0,0, 1,1,0,0));
        tbl.push_back(mk(1,1,3,32'h33, 0,0,0, 0,2,3,   1,1,32'h11,2, 1,1,1,0));
        tbl.push_back(mk(1,1,5,32'h55, 1,4,32'h44, 0,4,3,   1,1,32'h11,3, 0,1,0,1));
        // full: both readies 0 even while popping
        tbl.push_back(mk(1,1,6,32'h66, 1,6,32'h66, 1,4,5,   1,1,32'h11,4, 0,0,1,0));
        tbl.push_back(mk(1,0,0,0, 0,0,0, 0,1,2,   1,2,32'h22,3, 1,1,0,1));
        // reset mid-operation: pop in reset cycle ignored, contents discarded
        tbl.push_back(mk(0,0,0,0, 0,0,0, 1,2,0,   1,2,32'h22,3, 1,1,1,0));
        tbl.push_back(mk(1,0,0,0, 0,0,0, 1,2,3,   0,0,0,0, 1,1,0,0));
        tbl.push_back(mk(1,0,0,0, 0,0,0, 0,2,3,   0,0,0,0, 1,1,0,0));
        // push+pop at count 1: count stays 1, head moves to new entry
        tbl.push_back(mk(1,1,11,32'hB1, 0,0,0, 0,11,12,   0,0,0,0, 1,1,0,0));
        tbl.push_back(mk(1,1,12,32'hC2, 0,0,0, 1,11,12,   1,11,32'hB1,1, 1,1,1,0));
        tbl.push_back(mk(1,0,0,0, 0,0,0, 1,11,12,   1,12,32'hC2,1, 1,1,0,1));
        tbl.push_back(mk(1,0,0,0, 0,0,0, 0,11,12,   0,0,0,0, 1,1,0,0));

        // two reset cycles before anything is compared
        v = mk(0,0,0,0, 0,0,0, 0,5,0, 0,0,0,0, 0,0,0,0);
        step(v, 0, -1);
        step(v, 0, -1);

        foreach (tbl[i]) step(tbl[i], 1, i);

        for (int n = 0; n < 3000; n++) begin
            v       = mk(1,0,0,0, 0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0);
            v.rst   = ($urandom_range(0, 149) != 0);
            v.av    = $urandom_range(0, 1);
            v.ard   = 5'($urandom_range(0, 7));
            v.adata = $urandom;
            v.mv    = $urandom_range(0, 1);
            v.mrd   = 5'($urandom_range(0, 7));
            v.mdata = $urandom;
            v.acc   = ($urandom_range(0, 2) != 0);
            v.q1    = 5'($urandom_range(0, 7));
            v.q2    = 5'($urandom_range(0, 7));
            step(v, 2, n);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
